// File: rtl/rotary_consumer.sv
// Rotary-encoder token consumer: pops tokens from a conveyor and uses them to walk a menu
// (select mode) or to nudge the selected item's stored value (edit mode).
module rotary_consumer #(
  parameter int ITEMS   = 8,
  parameter int VAL_W   = 8,
  parameter int VAL_MAX = 255,
  parameter int HOLDOFF = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               data,
  output logic                     data_next,
  input  logic                     pause,
  output logic                     mode,
  output logic [$clog2(ITEMS)-1:0] item,
  output logic [VAL_W-1:0]         value,
  output logic                     update
);

  localparam int IW = $clog2(ITEMS);
  localparam logic [IW-1:0]    LAST_ITEM = IW'(ITEMS - 1);
  localparam logic [VAL_W-1:0] VMAX      = VAL_W'(VAL_MAX);
  localparam logic [7:0]       HOLD      = 8'(HOLDOFF);

  localparam logic [1:0] TOK_CCW = 2'b01;
  localparam logic [1:0] TOK_CW  = 2'b10;
  localparam logic [1:0] TOK_BTN = 2'b11;

  typedef enum logic [1:0] {IDLE, POP, APPLY, WAIT} state_t;

  state_t           state_q, state_d;
  logic [1:0]       tok_q, tok_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [IW-1:0]    item_q, item_d;
  logic             dn_q, dn_d;
  logic             upd_q, upd_d;
  logic [VAL_W-1:0] vals_q [ITEMS];
  logic [VAL_W-1:0] vals_d [ITEMS];
  logic [VAL_W-1:0] cur;

  assign cur = vals_q[item_q];

  always_comb begin
    state_d = state_q;
    tok_d   = tok_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    item_d  = item_q;
    vals_d  = vals_q;
    dn_d    = 1'b0;
    upd_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // The strobe is raised only after the token is latched, so the head never moves under us.
        if (data != 2'b00 && !pause) begin
          tok_d   = data;
          dn_d    = 1'b1;
          state_d = POP;
        end
      end
      POP: state_d = APPLY;
      APPLY: begin
        case (tok_q)
          TOK_CW: begin
            if (!mode_q) begin
              item_d = (item_q == LAST_ITEM) ? '0 : item_q + 1'b1;
              upd_d  = 1'b1;
            end else if (cur < VMAX) begin
              vals_d[item_q] = cur + 1'b1;
              upd_d          = 1'b1;
            end
          end
          TOK_CCW: begin
            if (!mode_q) begin
              item_d = (item_q == '0) ? LAST_ITEM : item_q - 1'b1;
              upd_d  = 1'b1;
            end else if (cur != '0) begin
              vals_d[item_q] = cur - 1'b1;
              upd_d          = 1'b1;
            end
          end
          TOK_BTN: begin
            mode_d = ~mode_q;
            upd_d  = 1'b1;
          end
          default: ;
        endcase
        if (HOLDOFF == 0) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          cnt_d   = HOLD;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tok_q   <= 2'b00;
      cnt_q   <= 8'd0;
      mode_q  <= 1'b0;
      item_q  <= '0;
      dn_q    <= 1'b0;
      upd_q   <= 1'b0;
      vals_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      tok_q   <= tok_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      item_q  <= item_d;
      dn_q    <= dn_d;
      upd_q   <= upd_d;
      vals_q  <= vals_d;
    end
  end

  assign data_next = dn_q;
  assign mode      = mode_q;
  assign item      = item_q;
  assign value     = cur;
  assign update    = upd_q;

endmodule

// File: tb/tb_rotary_consumer.sv
// Bench for rotary_consumer: a timestamp-based model of token acceptance/application,
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_rotary_consumer;

  localparam int ITEMS   = 8;
  localparam int VAL_W   = 8;
  localparam int VAL_MAX = 5;
  localparam int HOLDOFF = 4;
  localparam int IW      = $clog2(ITEMS);

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       data;
  logic             pause;
  logic             data_next;
  logic             mode;
  logic [IW-1:0]    item;
  logic [VAL_W-1:0] value;
  logic             update;

  always #5 clk = ~clk;

  rotary_consumer #(
    .ITEMS(ITEMS), .VAL_W(VAL_W), .VAL_MAX(VAL_MAX), .HOLDOFF(HOLDOFF)
  ) dut (
    .clk(clk), .rst(rst), .data(data), .data_next(data_next), .pause(pause),
    .mode(mode), .item(item), .value(value), .update(update)
  );

  int nVec = 0;
  int nMis = 0;

  // Model: an accepted token pops one edge later, applies two edges later,
  // and the consumer is ready again 3+HOLDOFF edges after acceptance.
  int         e = 0;
  int         readyEdge = 0;
  int         applyEdge = -10;
  logic [1:0] pendTok = 2'b00;
  int         mMode, mItem;
  int         mVals [ITEMS];
  bit         mDn, mUpd;

  logic [1:0] conv [$];
  bit         dnSeen = 0;
  bit         pauseVal = 0;
  int         updCount = 0;

  function automatic void modelReset();
    mMode = 0;
    mItem = 0;
    foreach (mVals[i]) mVals[i] = 0;
    mDn = 0;
    mUpd = 0;
    applyEdge = -10;
    readyEdge = e;
  endfunction

  function automatic void applyToken(logic [1:0] t);
    case (t)
      2'b10: begin
        if (mMode == 0) begin mItem = (mItem + 1) % ITEMS; mUpd = 1; end
        else if (mVals[mItem] < VAL_MAX) begin mVals[mItem] = mVals[mItem] + 1; mUpd = 1; end
      end
      2'b01: begin
        if (mMode == 0) begin mItem = (mItem + ITEMS - 1) % ITEMS; mUpd = 1; end
        else if (mVals[mItem] > 0) begin mVals[mItem] = mVals[mItem] - 1; mUpd = 1; end
      end
      2'b11: begin mMode = 1 - mMode; mUpd = 1; end
      default: ;
    endcase
  endfunction

  function automatic void modelEdge();
    e++;
    mDn = 0;
    mUpd = 0;
    if (rst) begin
      modelReset();
    end else begin
      if (e == applyEdge) applyToken(pendTok);
      if (e >= readyEdge && data != 2'b00 && !pause) begin
        pendTok   = data;
        mDn       = 1;
        applyEdge = e + 2;
        readyEdge = e + 3 + HOLDOFF;
      end
    end
  endfunction

  task automatic checkVal(input string name, input int act, input int exp);
    nVec++;
    if (act != exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkVal("data_next", int'(data_next), int'(mDn));
    checkVal("mode", int'(mode), mMode);
    checkVal("item", int'(item), mItem);
    checkVal("value", int'(value), mVals[mItem]);
    checkVal("update", int'(update), int'(mUpd));
  endtask

  task automatic cycle();
    @(posedge clk);
    modelEdge();
    #1;
    if (dnSeen && conv.size() > 0) void'(conv.pop_front());
    data  = (conv.size() > 0) ? conv[0] : 2'b00;
    pause = pauseVal;
    @(negedge clk);
    checkOutput();
    dnSeen = data_next;
    if (update) updCount++;
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) cycle();
  endtask

  task automatic releaseReset();
    @(posedge clk);
    modelEdge();
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput();
    dnSeen = data_next;
  endtask

  // Asserted mid-cycle, away from either clock edge, to exercise the asynchronous path.
  task automatic asyncReset(input int hold);
    #2 rst = 1'b1;
    modelReset();
    dnSeen = 0;
    #1;
    checkVal("rst_async_data_next", int'(data_next), 0);
    checkOutput();
    applyStimulus(hold);
    releaseReset();
  endtask

  task automatic runUntilIdle(input int maxc);
    int k = 0;
    while ((conv.size() != 0 || e < readyEdge) && k < maxc) begin
      cycle();
      k++;
    end
    if (k >= maxc) checkVal("idle_timeout", 1, 0);
  endtask

  initial begin
    int lastE, np, nu, u0, k;
    rst = 1'b1;
    data = 2'b00;
    pause = 1'b0;
    modelReset();
    @(negedge clk);
    checkVal("reset_data_next", int'(data_next), 0);
    checkVal("reset_mode", int'(mode), 0);
    checkVal("reset_item", int'(item), 0);
    checkVal("reset_value", int'(value), 0);
    checkVal("reset_update", int'(update), 0);
    checkOutput();
    releaseReset();

    // Held CW: one pop per 7 cycles, item walks round the menu
    repeat (9) conv.push_back(2'b10);
    np = 0; nu = 0; lastE = 0; k = 0;
    while (np < 9 && k < 100) begin
      cycle();
      k++;
      if (data_next) begin
        if (np > 0) checkVal("pop_period", e - lastE, 7);
        lastE = e;
        np++;
      end
      if (update) begin
        nu++;
        checkVal("cw_item_step", int'(item), nu % ITEMS);
      end
    end
    if (np < 9) checkVal("cw_pop_timeout", np, 9);
    runUntilIdle(50);
    checkVal("cw_item_final", int'(item), 1);

    // CCW at item 0 wraps to the last item
    asyncReset(2);
    u0 = updCount;
    conv.push_back(2'b01);
    runUntilIdle(30);
    checkVal("ccw_wrap_item", int'(item), 7);
    checkVal("ccw_wrap_mode", int'(mode), 0);
    checkVal("ccw_wrap_updates", updCount - u0, 1);

    // Edit mode with saturation at VAL_MAX
    asyncReset(1);
    u0 = updCount;
    conv.push_back(2'b11);
    repeat (6) conv.push_back(2'b10);
    runUntilIdle(100);
    checkVal("sat_mode", int'(mode), 1);
    checkVal("sat_value", int'(value), 5);
    checkVal("sat_updates", updCount - u0, 6);
    conv.push_back(2'b11);
    runUntilIdle(30);
    checkVal("sat_exit_mode", int'(mode), 0);
    checkVal("sat_exit_value", int'(value), 5);

    // Values of non-selected items are retained
    asyncReset(1);
    conv.push_back(2'b10); conv.push_back(2'b10); conv.push_back(2'b11);
    repeat (3) conv.push_back(2'b10);
    conv.push_back(2'b11); conv.push_back(2'b10);
    runUntilIdle(150);
    checkVal("retain_item3", int'(item), 3);
    checkVal("retain_value3", int'(value), 0);
    conv.push_back(2'b01);
    runUntilIdle(30);
    checkVal("retain_item2", int'(item), 2);
    checkVal("retain_value2", int'(value), 3);

    // Pause blocks pops; release lets the pending token through quickly
    pauseVal = 1;
    conv.push_back(2'b10);
    applyStimulus(2);
    for (int i = 0; i < 20; i++) begin
      cycle();
      checkVal("pause_no_pop", int'(data_next), 0);
    end
    pauseVal = 0;
    k = 0;
    do begin
      cycle();
      k++;
    end while (!data_next && k < 3);
    checkVal("pause_release_pop", int'(data_next), 1);
    runUntilIdle(30);
    checkVal("pause_item", int'(item), 3);

    // Reset during POP discards the token; it is popped afresh after release
    conv.push_back(2'b10);
    k = 0;
    while (!dnSeen && k < 12) begin
      cycle();
      k++;
    end
    checkVal("pop_reached", int'(dnSeen), 1);
    u0 = updCount;
    asyncReset(2);
    checkVal("pop_rst_item", int'(item), 0);
    checkVal("pop_rst_updates", updCount - u0, 0);
    k = 0;
    while (!data_next && k < 6) begin
      cycle();
      k++;
    end
    checkVal("pop_resume", int'(data_next), 1);
    runUntilIdle(30);
    checkVal("pop_resume_item", int'(item), 1);
    checkVal("pop_resume_updates", updCount - u0, 1);

    // Randomized traffic with pauses and one asynchronous reset
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0 && conv.size() < 3)
        conv.push_back(2'($urandom_range(1, 3)));
      pauseVal = ($urandom_range(0, 5) == 0);
      if (i == 300) asyncReset($urandom_range(1, 3));
      else cycle();
    end
    pauseVal = 0;
    runUntilIdle(200);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/rotary_consumer.md
ROTARY_CONSUMER -- requirements
Module: rotary_consumer

Interface
REQ-001 SHALL have parameter ITEMS, default 8: number of menu items, range 2..16.
REQ-002 SHALL have parameter VAL_W, default 8: width of each item value.
REQ-003 SHALL have parameter VAL_MAX, default 255: upper saturation bound of each value, at most 2^VAL_W-1.
REQ-004 SHALL have parameter HOLDOFF, default 4: idle cycles after each applied token, range 0..255.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port data, input, 2 bits: conveyor head token; 00 empty, 01 CCW, 10 CW, 11 button.
REQ-008 SHALL have port data_next, output, 1 bit: registered pop strobe; the conveyor advances on each clk edge where it is 1.
REQ-009 SHALL have port pause, input, 1 bit: blocks new pops while 1.
REQ-010 SHALL have port mode, output, 1 bit: 0 = select, 1 = edit.
REQ-011 SHALL have port item, output, clog2(ITEMS) bits: selected item index.
REQ-012 SHALL have port value, output, VAL_W bits: stored value of the selected item, combinational read of the value array.
REQ-013 SHALL have port update, output, 1 bit: one-cycle pulse when mode, item or value changed.

Function
REQ-014 SHALL implement FSM states IDLE, POP, APPLY, WAIT; all outputs except value registered.
REQ-015 In IDLE, at an edge with data!=00 and pause=0, SHALL latch data into token register tok and go to POP; otherwise stay in IDLE.
REQ-016 In POP, data_next SHALL be 1 for exactly one cycle; the next edge goes to APPLY; data_next is 0 in every other state.
REQ-017 SHALL never assert data_next while in IDLE, so a token is popped only after it is latched; the head token is stable while data_next=0.
REQ-018 APPLY, select mode: CW item+1, wrapping ITEMS-1->0; CCW item-1, wrapping 0->ITEMS-1; button sets mode=1.
REQ-019 APPLY, edit mode: CW values[item]+1, saturating at VAL_MAX; CCW values[item]-1, saturating at 0; button sets mode=0.
REQ-020 SHALL update the state of REQ-018/019 on the edge leaving APPLY, and update SHALL be 1 for the following cycle only if something changed; a saturated no-op gives update=0.
REQ-021 Leaving APPLY SHALL go to WAIT with a counter loaded to HOLDOFF, or to IDLE if HOLDOFF=0.
REQ-022 WAIT SHALL decrement the counter each cycle and go to IDLE on the edge where it reaches 0; WAIT lasts HOLDOFF cycles.
REQ-023 Latency: token visible at IDLE edge t gives data_next=1 in cycle t..t+1 and new outputs plus update in cycle t+2..t+3.
REQ-024 Throughput SHALL be one token per 3+HOLDOFF cycles.
REQ-025 pause SHALL be sampled only in IDLE; a pop in progress completes.
REQ-026 Values of non-selected items SHALL be retained across item changes and mode toggles.

Reset
REQ-027 While rst=1: state IDLE, data_next=0, update=0, mode=0, item=0, all values=0, tok=00, holdoff counter=0, applied asynchronously.
REQ-028 Reset asserted in POP SHALL drop data_next immediately; the latched token is discarded and not applied.
REQ-029 Reset asserted in APPLY or WAIT SHALL discard the pending update and the remaining holdoff.
REQ-030 After rst deasserts, the first pop SHALL not occur before the second rising edge.

Verification
REQ-031 Reset then data=10 held, HOLDOFF=4 -> data_next pulses every 7 cycles; item 0->1->...->7->0; update with each step.
REQ-032 Select mode, data=01 once at item=0 -> item=7, mode=0, update=1 for one cycle.
REQ-033 Button token then 6x CW, VAL_MAX=5 -> mode=1, value 0..5 with update on 5 steps, 6th step update=0, value=5; then button -> mode=0.
REQ-034 Edit item 2 to 3, button, CW to item 3, CCW back to item 2 -> value reads 0 at item 3 and 3 at item 2.
REQ-035 pause=1 with data=10 pending for 20 cycles -> data_next=0 throughout; pause=0 -> pop within 2 cycles.
REQ-036 rst pulse during the POP cycle -> data_next=0 same cycle, item=0, update never asserted, FSM resumes popping after release.
